// File: rtl/conc_pipe_pkg.sv
// rtl/conc_pipe_pkg.sv - shared constants and beat type for the conc_pipe datapath
//
// Purpose : default parameter values for conc_pipe and a packed beat type that
//           bundles the five results (a, b, c, d, e) at the default width.
// Ports   : none (package).
package conc_pipe_pkg;

  localparam int CONC_WIDTH     = 32;
  localparam int CONC_ADD_K     = 5;
  localparam int CONC_MUL_K     = 3;
  localparam int CONC_SUB_K     = 1;
  localparam int CONC_DIV_SHIFT = 2;

  typedef struct packed {
    logic [CONC_WIDTH-1:0] a;
    logic [CONC_WIDTH-1:0] b;
    logic [CONC_WIDTH-1:0] c;
    logic [CONC_WIDTH-1:0] d;
    logic [CONC_WIDTH-1:0] e;
  } conc_beat_t;

endpackage

// File: rtl/conc_pipe_slice.sv
// rtl/conc_pipe_slice.sv - valid/ready register slice with hold and synchronous flush
//
// Purpose : one pipeline register stage. Loads a new beat only when the
//           downstream side is ready (or the stage is empty); otherwise data
//           and valid hold. flush clears valid on the next edge, data is kept.
// Ports   : clk, rst (async active-low), flush,
//           in_valid / in_ready / in_data   : upstream side,
//           out_valid / out_ready / out_data : downstream side.
//           in_ready is combinational from out_ready (no skid buffer).
module conc_pipe_slice #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      // Data only moves with a real beat so outputs stay quiet on bubbles.
      if (in_valid) begin
        data_d = in_data;
      end
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/conc_pipe.sv
// rtl/conc_pipe.sv - two-stage pipelined constant arithmetic block with valid/ready
//
// Purpose : per accepted (i, j) computes a = i+ADD_K, b = a*MUL_K, c = a+b,
//           d = i-SUB_K, e = j>>DIV_SHIFT, all unsigned modulo 2^WIDTH.
//           Stage 1 registers a, d, e; stage 2 adds b and c. Latency 2,
//           throughput 1 beat/cycle, synchronous flush of both stages.
// Ports   : clk, rst (async active-low), flush,
//           in_valid / in_ready / i / j        : producer side,
//           out_valid / out_ready / a..e        : consumer side (registered).
module conc_pipe
  import conc_pipe_pkg::*;
#(
  parameter int WIDTH     = CONC_WIDTH,
  parameter int ADD_K     = CONC_ADD_K,
  parameter int MUL_K     = CONC_MUL_K,
  parameter int SUB_K     = CONC_SUB_K,
  parameter int DIV_SHIFT = CONC_DIV_SHIFT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] i,
  input  logic [WIDTH-1:0] j,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] e;
  } s1_beat_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] e;
  } s2_beat_t;

  s1_beat_t         s1_din, s1_dout;
  s2_beat_t         s2_din, s2_dout;
  logic             s1_in_valid, s1_rdy, s1_valid;
  logic             s2_rdy;
  logic [WIDTH-1:0] prod;

  // flush blocks acceptance outright so the flushed-cycle input never enters.
  assign s1_in_valid = in_valid && !flush;
  assign in_ready    = s1_rdy && !flush;

  always_comb begin
    s1_din   = '0;
    s1_din.a = i + WIDTH'(ADD_K);
    s1_din.d = i - WIDTH'(SUB_K);
    s1_din.e = j >> DIV_SHIFT;
  end

  conc_pipe_slice #(.WIDTH($bits(s1_beat_t))) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (s1_in_valid),
    .in_ready  (s1_rdy),
    .in_data   (s1_din),
    .out_valid (s1_valid),
    .out_ready (s2_rdy),
    .out_data  (s1_dout)
  );

  // The low WIDTH bits of a product depend only on the low WIDTH bits of the
  // operands, so a WIDTH-wide multiply equals the full product truncated.
  assign prod = s1_dout.a * WIDTH'(MUL_K);

  always_comb begin
    s2_din   = '0;
    s2_din.a = s1_dout.a;
    s2_din.b = prod;
    s2_din.c = s1_dout.a + prod;
    s2_din.d = s1_dout.d;
    s2_din.e = s1_dout.e;
  end

  conc_pipe_slice #(.WIDTH($bits(s2_beat_t))) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (s1_valid),
    .in_ready  (s2_rdy),
    .in_data   (s2_din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_dout)
  );

  assign a = s2_dout.a;
  assign b = s2_dout.b;
  assign c = s2_dout.c;
  assign d = s2_dout.d;
  assign e = s2_dout.e;

endmodule

// File: tb/tb_conc_pipe.sv
// tb/tb_conc_pipe.sv - directed self-checking bench for conc_pipe
module tb_conc_pipe;
  import conc_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] i, j;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a, b, c, d, e;

  int n_cmp = 0;
  int n_err = 0;

  conc_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i         (i),
    .j         (j),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e)
  );

  always #5 clk = ~clk;

  function automatic conc_beat_t model(input logic [31:0] ii, input logic [31:0] jj);
    conc_beat_t r;
    r.a = ii + 32'd5;
    r.b = r.a * 32'd3;
    r.c = r.a + r.b;
    r.d = ii - 32'd1;
    r.e = jj >> 2;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; i = '0; j = '0;
    #3;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_cmp++;
    if ({a, b, c, d, e} !== 160'd0) begin n_err++; $display("FAIL reset_data got=%h exp=0", {a, b, c, d, e}); end
    tick; tick;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic;
    i = 32'd10; j = 32'd100; in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early got=%b exp=0", out_valid); end
    tick;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    n_cmp++;
    if ({a, b, c, d, e} !== {32'd15, 32'd45, 32'd60, 32'd9, 32'd25})
      begin n_err++; $display("FAIL basic_data got=%h exp=%h", {a, b, c, d, e}, {32'd15, 32'd45, 32'd60, 32'd9, 32'd25}); end
    tick;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_single got=%b exp=0", out_valid); end
  endtask

  task automatic test_wrap;
    out_ready = 1'b1;
    i = 32'h5555_5555; j = 32'd3; in_valid = 1'b1;
    tick;
    i = 32'd0; j = 32'hFFFF_FFFF;
    tick;
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, a, b, c, d, e} !== {1'b1, 32'h5555_555A, 32'h0000_000E, 32'h5555_5568, 32'h5555_5554, 32'h0})
      begin n_err++; $display("FAIL wrap_hi got=%b %h exp=1 %h", out_valid, {a, b, c, d, e},
                              {32'h5555_555A, 32'h0000_000E, 32'h5555_5568, 32'h5555_5554, 32'h0}); end
    tick;
    n_cmp++;
    if ({out_valid, a, b, c, d, e} !== {1'b1, 32'd5, 32'd15, 32'd20, 32'hFFFF_FFFF, 32'h3FFF_FFFF})
      begin n_err++; $display("FAIL wrap_zero got=%b %h exp=1 %h", out_valid, {a, b, c, d, e},
                              {32'd5, 32'd15, 32'd20, 32'hFFFF_FFFF, 32'h3FFF_FFFF}); end
    tick;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0; j = 32'd0;
    i = 32'd1; in_valid = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_rdy1 got=%b exp=1", in_ready); end
    tick;
    i = 32'd2;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_rdy2 got=%b exp=1", in_ready); end
    tick;
    i = 32'd3;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_rdy3 got=%b exp=0", in_ready); end
    for (int k = 0; k < 4; k++) begin
      tick;
      n_cmp++;
      if ({out_valid, in_ready, a} !== {1'b1, 1'b0, 32'd6})
        begin n_err++; $display("FAIL bp_stall%0d got v=%b r=%b a=%0d exp v=1 r=0 a=6", k, out_valid, in_ready, a); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, a} !== {1'b1, 1'b1, 32'd6})
      begin n_err++; $display("FAIL bp_release got v=%b r=%b a=%0d exp v=1 r=1 a=6", out_valid, in_ready, a); end
    tick;
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, a} !== {1'b1, 32'd7}) begin n_err++; $display("FAIL bp_second got v=%b a=%0d exp v=1 a=7", out_valid, a); end
    tick;
    n_cmp++;
    if ({out_valid, a} !== {1'b1, 32'd8}) begin n_err++; $display("FAIL bp_third got v=%b a=%0d exp v=1 a=8", out_valid, a); end
    tick;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back;
    conc_beat_t q[$];
    conc_beat_t got, exp;
    int sent = 0;
    int recv = 0;
    int low  = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 110; cyc++) begin
      if (out_valid === 1'b1) begin
        got = {a, b, c, d, e};
        recv++;
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra got=%h exp=none", got);
        end else begin
          exp = q.pop_front();
          if (got !== exp) begin n_err++; $display("FAIL b2b_beat%0d got=%h exp=%h", recv, got, exp); end
        end
      end
      if (sent < 100) begin
        in_valid = 1'b1;
        i = 32'hF000_0000 + sent * 32'h0123_4567;
        j = 32'hFFFF_FFFF - sent * 32'd977;
        if (in_ready !== 1'b1) low++;
        else begin q.push_back(model(i, j)); sent++; end
      end else begin
        in_valid = 1'b0;
      end
      tick;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (low != 0) begin n_err++; $display("FAIL b2b_ready_low got=%0d exp=0", low); end
    n_cmp++;
    if (recv != 100) begin n_err++; $display("FAIL b2b_count got=%0d exp=100", recv); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0; j = 32'd0;
    i = 32'd20; in_valid = 1'b1;
    tick;
    i = 32'd21;
    tick;
    i = 32'd99; flush = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick;
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_cleared got=%b exp=0", out_valid); end
    out_ready = 1'b1;
    tick;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_stale got=%b exp=0", out_valid); end
    i = 32'd30; j = 32'd40; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    n_cmp++;
    if ({out_valid, a, b, c, d, e} !== {1'b1, 32'd35, 32'd105, 32'd140, 32'd29, 32'd10})
      begin n_err++; $display("FAIL flush_after got=%b %h exp=1 %h", out_valid, {a, b, c, d, e},
                              {32'd35, 32'd105, 32'd140, 32'd29, 32'd10}); end
    tick;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_tail got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midop;
    out_ready = 1'b0;
    i = 32'd40; j = 32'd8; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    n_cmp++;
    if ({out_valid, a} !== {1'b1, 32'd45}) begin n_err++; $display("FAIL rstmid_loaded got v=%b a=%0d exp v=1 a=45", out_valid, a); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    n_cmp++;
    if ({a, b, c, d, e} !== 160'd0) begin n_err++; $display("FAIL rstmid_data got=%h exp=0", {a, b, c, d, e}); end
    tick;
    #2;
    rst = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b01)
        begin n_err++; $display("FAIL rstmid_after%0d got v=%b r=%b exp v=0 r=1", k, out_valid, in_ready); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_back_to_back;
    test_flush;
    test_reset_midop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
